// File: rtl/route_1x2.sv
// rtl/route_1x2.sv - registered 1-to-2 word router with per-port valid/ready and transfer counters
module route_1x2 #(
    parameter int DATA_WIDTH  = 18,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_sel,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   a_valid,
    output logic [DATA_WIDTH-1:0]  a_data,
    input  logic                   a_ready,
    output logic                   b_valid,
    output logic [DATA_WIDTH-1:0]  b_data,
    input  logic                   b_ready,
    input  logic                   cnt_clr,
    output logic [COUNT_WIDTH-1:0] a_count,
    output logic [COUNT_WIDTH-1:0] b_count
);

    logic                   a_valid_q, a_valid_d;
    logic                   b_valid_q, b_valid_d;
    logic [DATA_WIDTH-1:0]  a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0]  b_data_q, b_data_d;
    logic [COUNT_WIDTH-1:0] a_count_q, a_count_d;
    logic [COUNT_WIDTH-1:0] b_count_q, b_count_d;

    logic a_free, b_free, load_a, load_b;

    always_comb begin
        // A slot draining this cycle can take a new word on the same edge, so full rate needs no bubble.
        a_free   = !a_valid_q || a_ready;
        b_free   = !b_valid_q || b_ready;
        in_ready = in_sel ? b_free : a_free;
        load_a   = in_valid && in_ready && !in_sel;
        load_b   = in_valid && in_ready && in_sel;

        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        if (a_valid_q && a_ready) a_valid_d = 1'b0;
        if (load_a) begin
            a_valid_d = 1'b1;
            a_data_d  = in_data;
        end

        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (b_valid_q && b_ready) b_valid_d = 1'b0;
        if (load_b) begin
            b_valid_d = 1'b1;
            b_data_d  = in_data;
        end

        // Clear wins over a same-cycle increment; the word itself is still routed.
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (cnt_clr) begin
            a_count_d = '0;
            b_count_d = '0;
        end else begin
            if (load_a) a_count_d = a_count_q + 1'b1;
            if (load_b) b_count_d = b_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;
    assign a_data  = a_data_q;
    assign b_data  = b_data_q;
    assign a_count = a_count_q;
    assign b_count = b_count_q;

endmodule
